stage_branch_reg: RTL
=====================

Name: stage_branch_reg

Overview:
- Stage/branch register stage that feeds the sequence generator: holds instruction stage (ST1/ST2) and branch flip-flops (BR1/BR2).
- Produces decoded stage lines ST0_..ST3_ and STD2, plus branch outputs BR1B2B and BR2_.
- Stage requests are latched as pending and transferred to the current stage at end of memory cycle (T12).
- Branch bits are loaded by test strobes from the write bus.

Parameters:
WL_W, 16, write-bus width (bit 16 = sign, bit 15 = overflow)

Ports:
CLOCK  input  1  system clock, all state on rising edge
rst  input  1  reset, synchronous, active-low
T12  input  1  one-cycle strobe, last pulse of memory cycle; stage transfer point
GOJAM  input  1  restart; synchronous clear of stage and branch state
INKL  input  1  counter-increment cycle in progress; inhibits STD2
ST1REQ  input  1  request stage bit 1 for next memory cycle
ST2REQ  input  1  request stage bit 2 for next memory cycle
TSGN  input  1  BR1 <= sign
TSGN2  input  1  BR2 <= sign
TOV  input  1  overflow test into BR1/BR2
TMZ  input  1  minus-zero test into BR2
TPZG  input  1  plus-zero/greater test into BR2
WL  input  WL_W  write bus, active-high data
ST0_  output 1  stage 0, active-low
ST1_  output 1  stage 1, active-low
ST2_  output 1  stage 2, active-low
ST3_  output 1  stage 3, active-low
STD2  output 1  stage 2 and not INKL, active-high
BR1  output 1  branch 1
BR2_  output 1  branch 2, active-low
BR1B2B  output 1  high when BR1=0 and BR2=0
STGERR  output 1  sticky illegal-request flag (see Optional Feature)

Behaviour:
- State: PST[2:1] pending stage, SG[2:1] current stage, BR1, BR2, STGERR.
- Reset (rst=0 at edge) and GOJAM=1: PST=0, SG=0, BR1=0, BR2=0, STGERR=0. Outputs: ST0_=0, ST1_=ST2_=ST3_=1, STD2=0, BR1=0, BR2_=1, BR1B2B=1. rst wins over every other input; GOJAM wins over all non-reset inputs.
- Pending: STnREQ=1 sets PST[n] at the edge; bits are sticky until the T12 edge.
- T12 edge: SG <= PST | {ST2REQ,ST1REQ}, so a request on the T12 cycle takes effect at this transfer, not the next. PST <= 0. SG holds on all other cycles.
- Stage decode is combinational from SG, so output latency is 0 after the edge. SG=0..3 maps to STn_ low, one-hot. STD2 = (SG==2) & ~INKL, combinational in INKL.
- Branch tests, sampled at the edge, using WL16 = WL[WL_W-1] and WL15 = WL[WL_W-2]:
  TSGN: BR1 <= WL16.
  TSGN2: BR2 <= WL16.
  TOV: BR1 <= WL16, BR2 <= WL16 ^ WL15.
  TMZ: BR2 <= (WL == all ones).
  TPZG: BR2 <= (WL == 0).
- Simultaneous strobes resolve per bit by priority. BR1: TOV > TSGN. BR2: TOV > TSGN2 > TMZ > TPZG.
- With no strobe, BR holds. BR is unaffected by T12.
- BR1B2B = ~BR1 & ~BR2. BR2_ = ~BR2.
- Mid-cycle GOJAM discards pending requests; the next T12 then loads 0 unless a request occurs on that cycle.

Optional Feature:
- Macro STG_ERRCHK_EN.
- Defined: STGERR sets (sticky) on any edge where INKL=1 and ST1REQ or ST2REQ=1, and also when T12 transfers SG=3 while the previous SG was also 3. Cleared only by rst or GOJAM.
- Undefined: STGERR is constant 0 and the detection logic is absent.

Decomposition:
- Package agc_stage_pkg: WL_W default, stage encodings STG0..STG3 (2-bit localparams), branch-priority constants.
- One sub-module, branch_ff_pair: BR1/BR2 registers, test-strobe priority, zero/ones detect on WL. The top holds the stage logic and decode.

Test Plan:
- Reset: rst=0 for 2 clocks with all inputs 1 -> ST0_=0, ST1_..ST3_=1, BR1=0, BR2_=1, BR1B2B=1, STGERR=0.
- Stage transfer: ST1REQ pulse at cycle 3, T12 at cycle 8 -> ST0_ stays 0 through cycle 8, ST1_=0 from cycle 9; second T12 with no request -> ST0_=0.
- Request on T12 cycle: ST2REQ and T12 same cycle -> ST2_=0 next cycle. With INKL=1, STD2=0; with INKL=0, STD2=1 (combinational).
- Branch tests:
  WL=16'h8000 + TSGN -> BR1=1.
  WL=16'h4000 + TOV -> BR1=0, BR2=1, BR1B2B=0.
  WL=16'hFFFF + TMZ -> BR2=1.
  WL=0 + TPZG -> BR2=1.
  WL=16'h0001 + TPZG -> BR2=0.
- Priority/GOJAM: TOV and TSGN2 together with WL=16'h8000 -> BR2=1 (TOV result). Then GOJAM with pending ST1REQ, followed by T12 -> SG=0, BR1=BR2=0.
- STG_ERRCHK_EN: INKL=1 with ST1REQ -> STGERR=1 next cycle and stays 1 until GOJAM. Without the macro -> STGERR always 0.

Source files
------------

// File: rtl/agc_stage_pkg.sv
// Shared constants for the stage/branch register: bus width, stage codes, branch-test priority.
package agc_stage_pkg;

  localparam int unsigned WL_W_DEF = 16;

  localparam logic [1:0] STG0 = 2'd0;
  localparam logic [1:0] STG1 = 2'd1;
  localparam logic [1:0] STG2 = 2'd2;
  localparam logic [1:0] STG3 = 2'd3;

  // Which test strobe wins a branch flop this cycle, highest priority last.
  typedef enum logic [2:0] {
    BrHold,
    BrTpzg,
    BrTmz,
    BrTsgn,
    BrTov
  } br_sel_e;

  function automatic br_sel_e br1_sel(input logic tov, input logic tsgn);
    if (tov)       return BrTov;
    else if (tsgn) return BrTsgn;
    else           return BrHold;
  endfunction

  function automatic br_sel_e br2_sel(input logic tov, input logic tsgn2, input logic tmz,
                                      input logic tpzg);
    if (tov)        return BrTov;
    else if (tsgn2) return BrTsgn;
    else if (tmz)   return BrTmz;
    else if (tpzg)  return BrTpzg;
    else            return BrHold;
  endfunction

endpackage

// File: rtl/branch_ff_pair.sv
// BR1/BR2 branch flip-flops loaded from the write bus by prioritised test strobes.
module branch_ff_pair
  import agc_stage_pkg::*;
#(
  parameter int unsigned WL_W = WL_W_DEF
) (
  input  logic            CLOCK,
  input  logic            rst,
  input  logic            GOJAM,
  input  logic            TSGN,
  input  logic            TSGN2,
  input  logic            TOV,
  input  logic            TMZ,
  input  logic            TPZG,
  input  logic [WL_W-1:0] WL,
  output logic            BR1,
  output logic            BR2
);

  logic    wl16, wl15, wl_ones, wl_zero;
  logic    br1_d, br2_d;
  br_sel_e sel1, sel2;

  assign wl16    = WL[WL_W-1];
  assign wl15    = WL[WL_W-2];
  assign wl_ones = &WL;
  assign wl_zero = ~|WL;

  always_comb begin
    sel1  = br1_sel(TOV, TSGN);
    sel2  = br2_sel(TOV, TSGN2, TMZ, TPZG);
    br1_d = BR1;
    br2_d = BR2;
    unique case (sel1)
      BrTov, BrTsgn: br1_d = wl16;
      default:       br1_d = BR1;
    endcase
    unique case (sel2)
      BrTov:   br2_d = wl16 ^ wl15;
      BrTsgn:  br2_d = wl16;
      BrTmz:   br2_d = wl_ones;
      BrTpzg:  br2_d = wl_zero;
      default: br2_d = BR2;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!rst || GOJAM) begin
      BR1 <= 1'b0;
      BR2 <= 1'b0;
    end else begin
      BR1 <= br1_d;
      BR2 <= br2_d;
    end
  end

endmodule

// File: rtl/stage_branch_reg.sv
// Stage (pending -> current at T12) and branch register feeding the sequence generator.
// Define STG_ERRCHK_EN to build the sticky illegal-request detector behind STGERR.
module stage_branch_reg
  import agc_stage_pkg::*;
#(
  parameter int unsigned WL_W = WL_W_DEF
) (
  input  logic            CLOCK,
  input  logic            rst,
  input  logic            T12,
  input  logic            GOJAM,
  input  logic            INKL,
  input  logic            ST1REQ,
  input  logic            ST2REQ,
  input  logic            TSGN,
  input  logic            TSGN2,
  input  logic            TOV,
  input  logic            TMZ,
  input  logic            TPZG,
  input  logic [WL_W-1:0] WL,
  output logic            ST0_,
  output logic            ST1_,
  output logic            ST2_,
  output logic            ST3_,
  output logic            STD2,
  output logic            BR1,
  output logic            BR2_,
  output logic            BR1B2B,
  output logic            STGERR
);

  logic [1:0] pst_q, sg_q;
  logic [1:0] pst_set;
  logic       br2;

  // A request on the T12 cycle joins this transfer rather than waiting a memory cycle.
  assign pst_set = pst_q | {ST2REQ, ST1REQ};

  always_ff @(posedge CLOCK) begin
    if (!rst || GOJAM) begin
      pst_q <= 2'b00;
      sg_q  <= STG0;
    end else if (T12) begin
      pst_q <= 2'b00;
      sg_q  <= pst_set;
    end else begin
      pst_q <= pst_set;
    end
  end

  assign ST0_ = (sg_q != STG0);
  assign ST1_ = (sg_q != STG1);
  assign ST2_ = (sg_q != STG2);
  assign ST3_ = (sg_q != STG3);
  assign STD2 = (sg_q == STG2) & ~INKL;

  branch_ff_pair #(
    .WL_W (WL_W)
  ) u_branch (
    .CLOCK (CLOCK),
    .rst   (rst),
    .GOJAM (GOJAM),
    .TSGN  (TSGN),
    .TSGN2 (TSGN2),
    .TOV   (TOV),
    .TMZ   (TMZ),
    .TPZG  (TPZG),
    .WL    (WL),
    .BR1   (BR1),
    .BR2   (br2)
  );

  assign BR2_   = ~br2;
  assign BR1B2B = ~BR1 & ~br2;

`ifdef STG_ERRCHK_EN
  logic stgerr_q;

  always_ff @(posedge CLOCK) begin
    if (!rst || GOJAM) begin
      stgerr_q <= 1'b0;
    end else if ((INKL && (ST1REQ || ST2REQ)) ||
                 (T12 && (pst_set == STG3) && (sg_q == STG3))) begin
      stgerr_q <= 1'b1;
    end
  end

  assign STGERR = stgerr_q;
`else
  assign STGERR = 1'b0;
`endif

endmodule
